// File: rtl/register_file.sv
// Sixteen-entry register file: one synchronous write port and two registered
// read ports with same-cycle write-to-read forwarding.
module register_file #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [3:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en_a,
    input  logic [3:0]           rd_addr_a,
    output logic [DATA_BITS-1:0] rd_data_a,
    output logic                 rd_valid_a,
    input  logic                 rd_en_b,
    input  logic [3:0]           rd_addr_b,
    output logic [DATA_BITS-1:0] rd_data_b,
    output logic                 rd_valid_b
);

    localparam int unsigned NUM_REGS = 16;

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] rd_next_a_c;
    logic [DATA_BITS-1:0] rd_next_b_c;

    // Storage array; register 0 is an ordinary register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Forward the in-flight write so a read in the same cycle never sees stale data.
    always_comb begin
        rd_next_a_c = regs[rd_addr_a];
        rd_next_b_c = regs[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_next_a_c = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_next_b_c = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) begin
                rd_data_a <= rd_next_a_c;
            end
            if (rd_en_b) begin
                rd_data_b <= rd_next_b_c;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, fill/readback,
// forwarding, hold behaviour and reset in the middle of a read.
module tb_register_file;

    localparam int unsigned DATA_BITS = 8;

    logic                 clk;
    logic                 reset_n;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_en_a;
    logic [3:0]           rd_addr_a;
    logic [DATA_BITS-1:0] rd_data_a;
    logic                 rd_valid_a;
    logic                 rd_en_b;
    logic [3:0]           rd_addr_b;
    logic [DATA_BITS-1:0] rd_data_b;
    logic                 rd_valid_b;

    int checks;
    int errors;

    register_file #(.DATA_BITS(DATA_BITS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_BITS-1:0] obs,
                       input logic [DATA_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 8'h00;
        rd_en_a   = 1'b0;
        rd_addr_a = 4'd0;
        rd_en_b   = 1'b0;
        rd_addr_b = 4'd0;

        #12;
        reset_n = 1'b1;

        // Put non-zero state on outputs so the async reset has something to clear.
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 4'd0;
        rd_en_b = 1'b1; rd_addr_b = 4'd0;
        tick();
        chk("pre_reset_fwd_a", rd_data_a, 8'hFF);
        chk_bit("pre_reset_valid_a", rd_valid_a, 1'b1);
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;

        // Asynchronous reset mid-cycle: outputs clear with no clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_data_a", rd_data_a, 8'h00);
        chk("async_rst_data_b", rd_data_b, 8'h00);
        chk_bit("async_rst_valid_a", rd_valid_a, 1'b0);
        chk_bit("async_rst_valid_b", rd_valid_b, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;

        // Every register reads zero; valid stays high for 16 straight cycles.
        rd_en_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            tick();
            chk($sformatf("rst_read_a%0d", i), rd_data_a, 8'h00);
            chk_bit($sformatf("rst_valid_a%0d", i), rd_valid_a, 1'b1);
        end
        rd_en_a = 1'b0;

        // Fill regs[i] = 0x10 + i.
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_addr = 4'(i);
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        chk_bit("valid_a_drops", rd_valid_a, 1'b0);

        // Readback: A walks up, B walks down.
        rd_en_a = 1'b1; rd_en_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            tick();
            chk($sformatf("fill_a%0d", i), rd_data_a, 8'(8'h10 + i));
            chk($sformatf("fill_b%0d", i), rd_data_b, 8'(8'h1F - i));
            chk_bit($sformatf("fill_valid_b%0d", i), rd_valid_b, 1'b1);
        end
        rd_en_a = 1'b0; rd_en_b = 1'b0;

        // Forwarding to both ports from the same write.
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h11;
        tick();
        wr_data = 8'hAB;
        rd_en_a = 1'b1; rd_addr_a = 4'd5;
        rd_en_b = 1'b1; rd_addr_b = 4'd5;
        tick();
        chk("fwd_a", rd_data_a, 8'hAB);
        chk("fwd_b", rd_data_b, 8'hAB);
        wr_en = 1'b0;
        tick();
        chk("fwd_stored_a", rd_data_a, 8'hAB);
        chk("fwd_stored_b", rd_data_b, 8'hAB);
        rd_en_b = 1'b0;

        // Neighbouring address is not forwarded.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h77;
        rd_addr_a = 4'd4;
        tick();
        chk("no_fwd_neighbour", rd_data_a, 8'h14);
        wr_en = 1'b0; rd_addr_a = 4'd3;
        tick();
        chk("stored_r3", rd_data_a, 8'h77);

        // Single read, then hold while regs[2] is overwritten.
        rd_addr_a = 4'd2;
        tick();
        chk("hold_read", rd_data_a, 8'h12);
        chk_bit("hold_valid_pulse", rd_valid_a, 1'b1);
        rd_en_a = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_data%0d", i), rd_data_a, 8'h12);
            chk_bit($sformatf("hold_valid%0d", i), rd_valid_a, 1'b0);
        end
        wr_en = 1'b0;

        // Reset asserted in the cycle a read of 7 is issued; that cycle's write is lost too.
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h5A;
        tick();
        wr_addr = 4'd9; wr_data = 8'hC3;
        rd_en_a = 1'b1; rd_addr_a = 4'd7;
        #1;
        reset_n = 1'b0;
        tick();
        chk_bit("midrst_no_valid", rd_valid_a, 1'b0);
        chk("midrst_data", rd_data_a, 8'h00);
        wr_en = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("midrst_r7", rd_data_a, 8'h00);
        chk_bit("midrst_valid_after", rd_valid_a, 1'b1);
        rd_addr_a = 4'd9;
        tick();
        chk("midrst_lost_write", rd_data_a, 8'h00);
        rd_en_a = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
